// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch T0-T2 then per-opcode execute T3-T7.
// Define MEM_WAIT_EN to add mem_ready wait states on read/write steps.
module control_sequencer #(
    parameter logic [4:0] ALU_ADD = 5'b00011,
    parameter int         CNT_W   = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [31:0]      ir,
    input  logic             con_ff,
`ifdef MEM_WAIT_EN
    input  logic             mem_ready,
`endif
    output logic [26:0]      ctrl,
    output logic [4:0]       aluControl,
    output logic             run,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);
    localparam int PCOUT = 0, INCPC = 1, ZLOOUT = 2, ZLOIN = 3, COUT = 4;
    localparam int MDROUT = 5, RAMEN = 6, MARIN = 7, PCIN = 8, MDRIN = 9;
    localparam int IRIN = 10, GRA = 11, GRB = 12, GRC = 13, RIN = 14;
    localparam int ROUT = 15, BAOUT = 16, READ = 17, WRITE = 18;
    localparam int CONIN = 19, ZMUXEN = 20, ZMUXOUT = 22, YIN = 26;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t           r_state;
    logic [26:0]      r_ctrl;
    logic [4:0]       r_alu;
    logic             r_run;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cnt;

    state_t      w_nstate;
    logic [26:0] w_nctrl;
    logic [4:0]  w_nalu;
    logic        w_alu_we;
    logic        w_retire;
    logic        w_bad;
    logic        w_mem_ok;
    logic [4:0]  w_op;
    logic [4:0]  w_imap;
    logic        w_ld, w_ldi, w_st, w_rt, w_it, w_br, w_nop, w_halt;
    logic        w_legal;
    logic        w_unused;

    assign w_op     = ir[31:27];
    assign w_unused = ^ir[26:0];
    assign w_ld     = (w_op == 5'b00000);
    assign w_ldi    = (w_op == 5'b00001);
    assign w_st     = (w_op == 5'b00010);
    assign w_rt     = (w_op >= 5'b00011) && (w_op <= 5'b00110);
    assign w_it     = (w_op >= 5'b01100) && (w_op <= 5'b01110);
    assign w_br     = (w_op == 5'b10010);
    assign w_nop    = (w_op == 5'b11010);
    assign w_halt   = (w_op == 5'b11011);
    assign w_legal  = w_ld | w_ldi | w_st | w_rt | w_it | w_br | w_nop | w_halt;
    assign w_imap   = (w_op == 5'b01100) ? 5'b00011 :
                      (w_op == 5'b01101) ? 5'b00101 : 5'b00110;

`ifdef MEM_WAIT_EN
    assign w_mem_ok = mem_ready;
`else
    assign w_mem_ok = 1'b1;
`endif

    always_comb begin
        w_nstate = r_state;
        w_retire = 1'b0;
        w_bad    = 1'b0;
        case (r_state)
            S_RESET: w_nstate = S_T0;
            S_T0:    w_nstate = S_T1;
            S_T1:    if (w_mem_ok) w_nstate = S_T2;
            S_T2: begin
                if (w_halt) begin
                    w_nstate = S_HALT;
                end else if (w_nop || !w_legal) begin
                    w_nstate = S_T0;
                    w_retire = 1'b1;
                    w_bad    = !w_legal;
                end else begin
                    w_nstate = S_T3;
                end
            end
            S_T3: w_nstate = S_T4;
            S_T4: w_nstate = S_T5;
            S_T5: begin
                if (w_ld || w_st || w_br) begin
                    w_nstate = S_T6;
                end else begin
                    w_nstate = S_T0;
                    w_retire = 1'b1;
                end
            end
            S_T6: begin
                if (w_br) begin
                    w_nstate = S_T0;
                    w_retire = 1'b1;
                end else if (!w_ld || w_mem_ok) begin
                    w_nstate = S_T7;
                end
            end
            S_T7: begin
                if (!w_st || w_mem_ok) begin
                    w_nstate = S_T0;
                    w_retire = 1'b1;
                end
            end
            S_HALT:  w_nstate = S_HALT;
            default: w_nstate = S_RESET;
        endcase
    end

    // Strobes are decoded for the state being entered so they register with it.
    always_comb begin
        w_nctrl  = '0;
        w_nalu   = r_alu;
        w_alu_we = 1'b0;
        case (w_nstate)
            S_T0: {w_nctrl[PCOUT], w_nctrl[MARIN], w_nctrl[INCPC]} = 3'b111;
            S_T1: {w_nctrl[READ], w_nctrl[RAMEN], w_nctrl[MDRIN]} = 3'b111;
            S_T2: {w_nctrl[MDROUT], w_nctrl[IRIN]} = 2'b11;
            S_T3: begin
                if (w_br)
                    {w_nctrl[GRA], w_nctrl[ROUT], w_nctrl[CONIN]} = 3'b111;
                else if (w_ld || w_ldi || w_st)
                    {w_nctrl[GRB], w_nctrl[BAOUT], w_nctrl[YIN]} = 3'b111;
                else
                    {w_nctrl[GRB], w_nctrl[ROUT], w_nctrl[YIN]} = 3'b111;
            end
            S_T4: begin
                if (w_br) begin
                    {w_nctrl[PCOUT], w_nctrl[YIN]} = 2'b11;
                end else if (w_rt) begin
                    {w_nctrl[GRC], w_nctrl[ROUT], w_nctrl[ZLOIN]} = 3'b111;
                    w_nalu   = w_op;
                    w_alu_we = 1'b1;
                end else begin
                    {w_nctrl[COUT], w_nctrl[ZLOIN]} = 2'b11;
                    w_nalu   = w_it ? w_imap : ALU_ADD;
                    w_alu_we = 1'b1;
                end
            end
            S_T5: begin
                if (w_br) begin
                    {w_nctrl[COUT], w_nctrl[ZLOIN]} = 2'b11;
                    w_nalu   = ALU_ADD;
                    w_alu_we = 1'b1;
                end else if (w_ldi) begin
                    {w_nctrl[ZMUXEN], w_nctrl[ZMUXOUT]} = 2'b11;
                    {w_nctrl[GRA], w_nctrl[RIN]} = 2'b11;
                end else if (w_ld || w_st) begin
                    {w_nctrl[ZLOOUT], w_nctrl[MARIN]} = 2'b11;
                end else begin
                    {w_nctrl[ZLOOUT], w_nctrl[GRA], w_nctrl[RIN]} = 3'b111;
                end
            end
            S_T6: begin
                if (w_br)
                    {w_nctrl[ZLOOUT], w_nctrl[PCIN]} = {2{con_ff}};
                else if (w_ld)
                    {w_nctrl[READ], w_nctrl[RAMEN], w_nctrl[MDRIN]} = 3'b111;
                else
                    {w_nctrl[GRA], w_nctrl[ROUT], w_nctrl[MDRIN]} = 3'b111;
            end
            S_T7: begin
                if (w_ld)
                    {w_nctrl[MDROUT], w_nctrl[GRA], w_nctrl[RIN]} = 3'b111;
                else
                    {w_nctrl[WRITE], w_nctrl[RAMEN]} = 2'b11;
            end
            default: w_nctrl = '0;
        endcase
    end

    always_ff @(negedge clock or negedge clear) begin
        if (!clear) begin
            r_state   <= S_RESET;
            r_ctrl    <= '0;
            r_alu     <= '0;
            r_run     <= 1'b1;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_nstate;
            r_ctrl  <= w_nctrl;
            r_run   <= (w_nstate != S_HALT);
            if (w_alu_we) r_alu <= w_nalu;
            if (w_bad)    r_illegal <= 1'b1;
            if (w_retire) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign ctrl        = r_ctrl;
    assign aluControl  = r_alu;
    assign run         = r_run;
    assign illegal     = r_illegal;
    assign instr_count = r_cnt;
endmodule
